// File: rtl/uart_pkg.sv
// Shared UART types, parity/stop encodings and parity helper.
// UART_BREAK_DETECT_EN adds the RX BREAK_WAIT state.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
`ifdef UART_BREAK_DETECT_EN
    , RX_BREAK_WAIT
`endif
  } rx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam logic STOP_ONE    = 1'b0;
  localparam logic STOP_TWO    = 1'b1;

  function automatic logic parity_bit(
    input logic x,
    input logic odd
  );
    return (odd == PARITY_EVEN) ? x : ~x;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Sample-tick divider plus per-bit tick counter; strobe fires on
// tick number SAMPLE_AT+1 of every bit period after clr.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int SAMPLE_AT  = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 strobe
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HIT  = CW'(SAMPLE_AT);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 tick;

  always_comb begin
    tick   = en && (div_q >= baud_div);
    div_d  = div_q + 1'b1;
    cnt_d  = cnt_q;
    if (!en || clr) begin
      div_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      div_d = '0;
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
    strobe = tick && (cnt_q == HIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART with oversampled RX and latched frame config.
// Define UART_BREAK_DETECT_EN to enable break reporting on RX.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 uart_en,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_enable,
  input  logic                 parity_odd,
  input  logic                 stop_bits2,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_error,
  output logic                 rx_frame_error,
  output logic                 rx_overrun,
  output logic                 rx_break,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_t            tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [BW-1:0]        tx_idx_q, tx_idx_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_pen_q, tx_pen_d;
  logic                 tx_st2_q, tx_st2_d;
  logic                 tx_stop_idx_q, tx_stop_idx_d;
  logic                 tx_clr, tx_strobe;

  rx_state_t            rx_state_q, rx_state_d;
  logic                 rx_s1_q, rx_s1_d;
  logic                 rx_s2_q, rx_s2_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [BW-1:0]        rx_idx_q, rx_idx_d;
  logic                 rx_pen_q, rx_pen_d;
  logic                 rx_odd_q, rx_odd_d;
  logic                 rx_pbit_q, rx_pbit_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_ovr_q, rx_ovr_d;
  logic                 rx_clr, rx_strobe;
  logic                 rx_ack, rx_pend, rx_perr_now;

  uart_baud_gen #(
    .OVERSAMPLE(OVERSAMPLE),
    .DIV_WIDTH (DIV_WIDTH),
    .SAMPLE_AT (OVERSAMPLE - 1)
  ) u_tx_baud (
    .clock   (clock),
    .reset   (reset),
    .en      (uart_en),
    .clr     (tx_clr),
    .baud_div(baud_div),
    .strobe  (tx_strobe)
  );

  uart_baud_gen #(
    .OVERSAMPLE(OVERSAMPLE),
    .DIV_WIDTH (DIV_WIDTH),
    .SAMPLE_AT (OVERSAMPLE / 2 - 1)
  ) u_rx_baud (
    .clock   (clock),
    .reset   (reset),
    .en      (uart_en),
    .clr     (rx_clr),
    .baud_div(baud_div),
    .strobe  (rx_strobe)
  );

  assign tx_ready = uart_en && !reset
                 && (tx_state_q == TX_IDLE);
  assign busy = (tx_state_q != TX_IDLE)
             || (rx_state_q != RX_IDLE);

  always_comb begin
    tx_state_d    = tx_state_q;
    tx_shift_d    = tx_shift_q;
    tx_idx_d      = tx_idx_q;
    tx_par_d      = tx_par_q;
    tx_pen_d      = tx_pen_q;
    tx_st2_d      = tx_st2_q;
    tx_stop_idx_d = tx_stop_idx_q;
    tx_clr        = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: if (tx_valid && tx_ready) begin
        tx_shift_d = tx_data;
        tx_par_d   = parity_bit(^tx_data, parity_odd);
        tx_pen_d   = parity_enable;
        tx_st2_d   = stop_bits2;
        tx_clr     = 1'b1;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_strobe) begin
        tx_idx_d      = '0;
        tx_stop_idx_d = 1'b0;
        tx_state_d    = TX_DATA;
      end
      TX_DATA: if (tx_strobe) begin
        tx_shift_d = tx_shift_q >> 1;
        tx_idx_d   = tx_idx_q + 1'b1;
        if (tx_idx_q == LAST_BIT)
          tx_state_d = tx_pen_q ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: if (tx_strobe) tx_state_d = TX_STOP;
      TX_STOP: if (tx_strobe) begin
        if (tx_st2_q == STOP_ONE || tx_stop_idx_q)
          tx_state_d = TX_IDLE;
        else
          tx_stop_idx_d = 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (!uart_en) tx_state_d = TX_IDLE;
  end

  always_comb begin
    unique case (tx_state_q)
      TX_START:  tx_out = 1'b0;
      TX_DATA:   tx_out = tx_shift_q[0];
      TX_PARITY: tx_out = tx_par_q;
      default:   tx_out = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q    <= TX_IDLE;
      tx_shift_q    <= '0;
      tx_idx_q      <= '0;
      tx_par_q      <= 1'b0;
      tx_pen_q      <= 1'b0;
      tx_st2_q      <= STOP_ONE;
      tx_stop_idx_q <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_shift_q    <= tx_shift_d;
      tx_idx_q      <= tx_idx_d;
      tx_par_q      <= tx_par_d;
      tx_pen_q      <= tx_pen_d;
      tx_st2_q      <= tx_st2_d;
      tx_stop_idx_q <= tx_stop_idx_d;
    end
  end

  // A handshake frees the holding register in the same cycle.
  assign rx_ack  = rx_valid_q && rx_ready;
  assign rx_pend = rx_valid_q && !rx_ack;
  assign rx_perr_now = rx_pen_q && (rx_pbit_q
    != parity_bit(^rx_shift_q, rx_odd_q));

`ifdef UART_BREAK_DETECT_EN
  logic rx_brk_q, rx_brk_d;
  assign rx_break = rx_brk_q;
`else
  assign rx_break = 1'b0;
`endif

  always_comb begin
    rx_s1_d    = rx_in;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_idx_d   = rx_idx_q;
    rx_pen_d   = rx_pen_q;
    rx_odd_d   = rx_odd_q;
    rx_pbit_d  = rx_pbit_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_ovr_d   = rx_ovr_q;
    rx_clr     = 1'b0;
`ifdef UART_BREAK_DETECT_EN
    rx_brk_d   = rx_brk_q;
`endif
    if (rx_ack) begin
      rx_valid_d = 1'b0;
      rx_perr_d  = 1'b0;
      rx_ferr_d  = 1'b0;
      rx_ovr_d   = 1'b0;
`ifdef UART_BREAK_DETECT_EN
      rx_brk_d   = 1'b0;
`endif
    end
    unique case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_clr     = 1'b1;
        rx_pen_d   = parity_enable;
        rx_odd_d   = parity_odd;
        rx_state_d = RX_START;
      end
      RX_START: if (rx_strobe) begin
        rx_idx_d   = '0;
        rx_pbit_d  = 1'b0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_strobe) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
        rx_idx_d   = rx_idx_q + 1'b1;
        if (rx_idx_q == LAST_BIT)
          rx_state_d = rx_pen_q ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_strobe) begin
        rx_pbit_d  = rx_s2_q;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_strobe) begin
        rx_state_d = RX_IDLE;
        if (rx_pend) begin
          rx_ovr_d   = 1'b1;
        end else begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          rx_perr_d  = rx_perr_now;
          rx_ferr_d  = !rx_s2_q;
        end
`ifdef UART_BREAK_DETECT_EN
        if (!rx_s2_q && rx_shift_q == '0
            && !(rx_pen_q && rx_pbit_q)) begin
          rx_idx_d   = '0;
          rx_state_d = RX_BREAK_WAIT;
          if (!rx_pend) rx_brk_d = 1'b1;
        end
`endif
      end
`ifdef UART_BREAK_DETECT_EN
      // Two strobes with the line high span a full bit period.
      RX_BREAK_WAIT: begin
        if (!rx_s2_q) begin
          rx_clr   = 1'b1;
          rx_idx_d = '0;
        end else if (rx_strobe) begin
          if (rx_idx_q[0]) rx_state_d = RX_IDLE;
          else             rx_idx_d   = BW'(1);
        end
      end
`endif
      default: rx_state_d = RX_IDLE;
    endcase
    if (!uart_en) rx_state_d = RX_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_shift_q <= '0;
      rx_idx_q   <= '0;
      rx_pen_q   <= 1'b0;
      rx_odd_q   <= PARITY_EVEN;
      rx_pbit_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rx_shift_q <= rx_shift_d;
      rx_idx_q   <= rx_idx_d;
      rx_pen_q   <= rx_pen_d;
      rx_odd_q   <= rx_odd_d;
      rx_pbit_q  <= rx_pbit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

`ifdef UART_BREAK_DETECT_EN
  always_ff @(posedge clock) begin
    if (reset) rx_brk_q <= 1'b0;
    else       rx_brk_q <= rx_brk_d;
  end
`endif

  assign rx_data         = rx_data_q;
  assign rx_valid        = rx_valid_q;
  assign rx_parity_error = rx_perr_q;
  assign rx_frame_error  = rx_ferr_q;
  assign rx_overrun      = rx_ovr_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: vector table, corner
// sequences and randomized frames against a bit-list reference model.
module tb_uart_transceiver;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int DW = 16;
`ifdef UART_BREAK_DETECT_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          uart_en = 1'b0;
  logic [DW-1:0] baud_div = '0;
  logic          parity_enable = 1'b0;
  logic          parity_odd = 1'b0;
  logic          stop_bits2 = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx_out;
  logic          rx_drv = 1'b1;
  logic          loopback = 1'b0;
  logic          rx_line;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic          rx_parity_error, rx_frame_error;
  logic          rx_overrun, rx_break, busy;

  int n_total = 0;
  int n_bad = 0;

  assign rx_line = loopback ? tx_out : rx_drv;

  always #5 clock = ~clock;

  uart_transceiver #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS),
    .DIV_WIDTH (DW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .uart_en        (uart_en),
    .baud_div       (baud_div),
    .parity_enable  (parity_enable),
    .parity_odd     (parity_odd),
    .stop_bits2     (stop_bits2),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_out         (tx_out),
    .rx_in          (rx_line),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_parity_error(rx_parity_error),
    .rx_frame_error (rx_frame_error),
    .rx_overrun     (rx_overrun),
    .rx_break       (rx_break),
    .busy           (busy)
  );

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] rx_snap();
    return {rx_valid, rx_parity_error, rx_frame_error,
            rx_break, rx_overrun, rx_data};
  endfunction

  // Expected RX report for a frame built from the given fields.
  function automatic logic [12:0] rx_model(
    input logic [7:0] d, input bit pen, input bit odd,
    input bit flip, input bit stopv);
    bit good_par, par, pe, brk;
    good_par = (^d) ^ odd;
    par      = good_par ^ flip;
    pe       = pen && (par != good_par);
    brk      = BRK_EN && d == 8'h00 && !stopv && !(pen && par);
    return {1'b1, pe, !stopv, brk, 1'b0, d};
  endfunction

  task automatic rx_ack();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] d, input bit pen,
                          input bit odd, input bit flip,
                          input bit stopv, input int bd);
    int p;
    p = OS * (bd + 1);
    baud_div = DW'(bd);
    parity_enable = pen;
    parity_odd = odd;
    rx_drv = 1'b0;
    step(p);
    for (int i = 0; i < DB; i++) begin
      rx_drv = d[i];
      step(p);
    end
    if (pen) begin
      rx_drv = (^d) ^ odd ^ flip;
      step(p);
    end
    rx_drv = stopv;
    step(p);
    rx_drv = 1'b1;
    step(3 * p);
  endtask

  // Sends one frame and checks tx_out every cycle plus tx_ready timing.
  task automatic send_tx(input logic [7:0] d, input bit pen,
                         input bit odd, input bit st2,
                         input int bd, input bit scramble);
    bit q[$];
    int p, n, w, errs, rdy_bad;
    p = OS * (bd + 1);
    q.push_back(1'b0);
    for (int i = 0; i < DB; i++) q.push_back(d[i]);
    if (pen) q.push_back((^d) ^ odd);
    q.push_back(1'b1);
    if (st2) q.push_back(1'b1);
    n = q.size();
    baud_div = DW'(bd);
    parity_enable = pen;
    parity_odd = odd;
    stop_bits2 = st2;
    tx_data = d;
    tx_valid = 1'b1;
    w = 0;
    while (tx_ready !== 1'b1 && w < 4000) begin
      step();
      w++;
    end
    if (w >= 4000) begin
      check("tx_ready_wait", 32'(tx_ready), 32'd1);
      tx_valid = 1'b0;
      return;
    end
    step();
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    if (scramble) begin
      parity_enable = 1'($urandom);
      parity_odd = 1'($urandom);
      stop_bits2 = 1'($urandom);
    end
    errs = 0;
    rdy_bad = 0;
    for (int c = 0; c < n * p; c++) begin
      if (tx_out !== q[c / p]) errs++;
      if (tx_ready !== 1'b0) rdy_bad++;
      step();
    end
    check($sformatf("tx_wave_%02h_errs", d), errs, 0);
    check($sformatf("tx_ready_end_%02h", d),
          {rdy_bad[15:0], 15'd0, tx_ready}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         pen, odd, flip, stopv;
    logic [7:0] e_data;
    bit         e_pe, e_fe;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int rises;
    logic prev;
    logic [7:0] d;
    bit pen, odd, flip, stopv, st2;
    int bd;

    tbl[0] = '{8'h55, 0, 0, 0, 0, 8'h55, 0, 1};
    tbl[1] = '{8'hA5, 1, 0, 0, 1, 8'hA5, 0, 0};
    tbl[2] = '{8'hA5, 1, 0, 1, 1, 8'hA5, 1, 0};
    tbl[3] = '{8'h3C, 1, 1, 0, 1, 8'h3C, 0, 0};
    tbl[4] = '{8'h00, 1, 1, 1, 1, 8'h00, 1, 0};
    tbl[5] = '{8'hFF, 0, 1, 1, 1, 8'hFF, 0, 0};
    tbl[6] = '{8'h81, 1, 1, 1, 0, 8'h81, 1, 1};

    uart_en = 1'b1;
    step(3);
    check("reset_state",
          {tx_out, tx_ready, busy, rx_snap()},
          {1'b1, 1'b0, 1'b0, 13'h0});
    reset = 1'b0;
    step(2);
    check("ready_after_reset", 32'(tx_ready), 32'd1);

    send_tx(8'hA5, 0, 0, 0, 3, 0);

    loopback = 1'b1;
    send_tx(8'h3C, 1, 1, 1, 3, 0);
    check("loopback_3c", rx_snap(), {1'b1, 4'b0, 8'h3C});
    rx_ack();
    loopback = 1'b0;
    check("loopback_ack", 32'(rx_valid), 32'd0);

    for (int i = 0; i < 7; i++) begin
      rx_frame(tbl[i].d, tbl[i].pen, tbl[i].odd,
               tbl[i].flip, tbl[i].stopv, 1);
      check($sformatf("vec%0d", i), rx_snap(),
            {1'b1, tbl[i].e_pe, tbl[i].e_fe, 2'b00,
             tbl[i].e_data});
      rx_ack();
      check($sformatf("vec%0d_ack", i),
            32'(rx_snap() >> 8), 32'd0);
    end

    baud_div = 1;
    rx_drv = 1'b0;
    step(OS / 4 * 2);
    rx_drv = 1'b1;
    step(4);
    check("glitch_busy", 32'(busy), 32'd1);
    step(OS * 2);
    check("glitch_idle", {busy, rx_valid}, 0);

    rx_frame(8'h11, 0, 0, 0, 1, 0);
    rx_frame(8'h22, 0, 0, 0, 1, 0);
    check("overrun", rx_snap(), {1'b1, 3'b0, 1'b1, 8'h11});
    rx_ack();
    check("overrun_clear",
          {rx_valid, rx_overrun}, 0);

    baud_div = 0;
    parity_enable = 1'b0;
    rx_drv = 1'b0;
    rises = 0;
    prev = rx_valid;
    for (int c = 0; c < 20 * OS; c++) begin
      step();
      if (rx_valid && !prev) rises++;
      prev = rx_valid;
    end
    check("break_count", rises, 1);
    rx_drv = 1'b1;
    step(3 * OS);
    check("break_flags", rx_snap(),
          {1'b1, 1'b0, 1'b1, BRK_EN, 1'b0, 8'h00});
    rx_ack();
    rx_frame(8'h5A, 0, 0, 0, 1, 0);
    check("after_break", rx_snap(), {1'b1, 4'b0, 8'h5A});
    rx_ack();

    rx_frame(8'h66, 0, 0, 0, 1, 0);
    baud_div = 1;
    tx_data = 8'h0F;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    step(100);
    check("en_busy", 32'(busy), 32'd1);
    uart_en = 1'b0;
    step();
    check("en_off", {tx_out, busy, tx_ready, rx_valid, rx_data},
          {4'b1001, 8'h66});
    uart_en = 1'b1;
    step();
    check("en_on", 32'(tx_ready), 32'd1);
    rx_ack();

    tx_data = 8'hC3;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    rx_drv = 1'b0;
    step(40);
    reset = 1'b1;
    rx_drv = 1'b1;
    step();
    check("reset_mid", {tx_out, busy, tx_ready, rx_valid},
          4'b1000);
    reset = 1'b0;
    step(3 * OS * 2);
    check("reset_after", {busy, rx_valid}, 0);

    for (int i = 0; i < 24; i++) begin
      d = (i % 7 == 0) ? 8'h00 : 8'($urandom);
      pen = 1'($urandom);
      odd = 1'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      stopv = ($urandom_range(0, 3) != 0);
      bd = $urandom_range(0, 2);
      rx_frame(d, pen, odd, flip, stopv, bd);
      check($sformatf("rand_rx%0d", i), rx_snap(),
            rx_model(d, pen, odd, flip, stopv));
      rx_ack();
    end

    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      pen = 1'($urandom);
      odd = 1'($urandom);
      st2 = 1'($urandom);
      bd = $urandom_range(0, 2);
      send_tx(d, pen, odd, st2, bd, 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
UART_TRANSCEIVER -- requirements
Module: uart_transceiver

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, character length (legal 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit (even, >=8).
REQ-003 SHALL have parameter DIV_WIDTH, default 16, width of baud_div.
REQ-004 SHALL have ports: clock in 1 system clock; reset in 1 synchronous active-high reset.
REQ-005 SHALL have ports: uart_en in 1 enable; baud_div in DIV_WIDTH tick divisor; parity_enable in 1; parity_odd in 1 (0=even); stop_bits2 in 1 (0=one stop, 1=two).
REQ-006 SHALL have TX ports: tx_data in DATA_BITS; tx_valid in 1; tx_ready out 1; tx_out out 1 serial line.
REQ-007 SHALL have RX ports: rx_in in 1 async serial line; rx_data out DATA_BITS; rx_valid out 1; rx_ready in 1; rx_parity_error, rx_frame_error, rx_overrun, rx_break out 1 each; busy out 1.

Function
REQ-008 SHALL generate a one-cycle sample tick every baud_div+1 clocks while uart_en=1; baud_div=0 gives a tick every cycle; bit period = OVERSAMPLE ticks.
REQ-009 SHALL latch parity_enable, parity_odd, stop_bits2 at each frame start; mid-frame config changes have no effect on that frame.
REQ-010 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; tx_ready=1 only in IDLE with uart_en=1.
REQ-011 TX SHALL accept data on tx_valid&&tx_ready, drive start bit (0) from the next cycle, then DATA_BITS LSB-first, optional parity, then 1 or 2 stop bits (1), each lasting one bit period.
REQ-012 Parity bit SHALL equal XOR of data bits, inverted when parity_odd=1.
REQ-013 TX SHALL return to IDLE on the cycle the last stop bit period ends; back-to-back frames SHALL have no idle gap.
REQ-014 RX SHALL pass rx_in through a 2-flop synchroniser reset to 1.
REQ-015 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK_WAIT; a synchronised 1->0 edge in IDLE enters START.
REQ-016 RX SHALL sample START at tick OVERSAMPLE/2; if sampled 1 it SHALL return to IDLE (glitch reject) without flags.
REQ-017 RX SHALL sample each subsequent bit OVERSAMPLE ticks after the previous sample (mid-bit); only the first stop bit is checked.
REQ-018 On the stop-bit sample, RX SHALL load rx_data, set rx_valid, and present rx_parity_error (parity mismatch) and rx_frame_error (stop=0) with it.
REQ-019 rx_valid and error flags SHALL hold until the cycle after rx_valid&&rx_ready.
REQ-020 If a frame completes while rx_valid=1, rx_data SHALL be kept, the new frame dropped, rx_overrun set sticky until the next rx_valid&&rx_ready handshake.
REQ-021 busy SHALL be 1 when either FSM is not in IDLE.
REQ-022 uart_en=0 SHALL force both FSMs to IDLE within one cycle, tx_out=1, tick counter cleared; pending rx_valid is retained.

Reset
REQ-023 Reset SHALL set: FSMs IDLE, tx_out=1, tx_ready=0, rx_data=0, rx_valid=0, all error flags 0, busy=0, counters 0, synchroniser 1.
REQ-024 Reset mid-frame SHALL abort both directions on the next clock edge; no partial frame is reported.

Configuration
REQ-025 With UART_BREAK_DETECT_EN defined, a frame with all data, parity and stop samples 0 SHALL assert rx_break with rx_frame_error and rx_valid (rx_data=0), then RX SHALL stay in BREAK_WAIT until rx_in is 1 for one full bit period.
REQ-026 Without UART_BREAK_DETECT_EN, rx_break SHALL be tied 0, BREAK_WAIT SHALL not exist, and a break is reported as an ordinary frame error.

Structure
REQ-027 Package uart_pkg SHALL hold tx_state_t, rx_state_t enums and parity/stop encoding constants.
REQ-028 Sub-module uart_baud_gen SHALL implement the tick divider and per-bit tick counting.

Verification
REQ-029 DATA_BITS=8, baud_div=3, 8N1, send 0xA5 -> tx_out 0,1,0,1,0,0,1,0,1,1 each 64 clocks; tx_ready high 640 clocks after handshake.
REQ-030 Loopback 0x3C, parity_enable=1, parity_odd=1, stop_bits2=1 -> rx_data=0x3C, parity bit 1, no error flags, two stop periods on tx_out.
REQ-031 Inject rx frame 0x55 with stop=0 -> rx_valid with rx_frame_error=1, rx_parity_error=0.
REQ-032 rx_in low pulse of OVERSAMPLE/4 ticks -> no rx_valid, RX returns IDLE, busy drops.
REQ-033 Two frames 0x11, 0x22 with rx_ready=0 -> rx_data=0x11, rx_overrun=1; rx_ready pulse clears both.
REQ-034 UART_BREAK_DETECT_EN, rx_in low for 20 bit periods -> one rx_valid with rx_break=1, rx_frame_error=1; next valid frame received normally after line high.
